// File: rtl/wb_pb_led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pb_led_ctrl_pkg
// Purpose  : Shared constants for the LED / push-button Wishbone slave.
//            Holds the register word indices (byte offset >> 2), the PB_STAT
//            bit positions and the BLINK_DIV field width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_pb_led_ctrl_pkg;

  // Width of the BLINK_DIV register and of the blink prescaler.
  localparam int BLINK_DIV_W = 24;

  // Register word indices, compared against wb_adr_i[4:2].
  localparam logic [2:0] REG_LED_OUT   = 3'd0;  // byte offset 0x00
  localparam logic [2:0] REG_LED_MODE  = 3'd1;  // byte offset 0x04
  localparam logic [2:0] REG_BLINK_DIV = 3'd2;  // byte offset 0x08
  localparam logic [2:0] REG_PB_STAT   = 3'd3;  // byte offset 0x0C
  localparam logic [2:0] REG_IRQ_EN    = 3'd4;  // byte offset 0x10

  // PB_STAT bit positions.
  localparam int PB_STAT_LEVEL_BIT = 0;
  localparam int PB_STAT_EVT_BIT   = 1;

endpackage
`default_nettype wire

// File: rtl/wb_pb_led_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_pb_led_ctrl_if
// Purpose  : Wishbone classic bus bundle between the SoC master and the
//            LED / push-button slave.
// Ports    : wb_adr_i[4:0], wb_dat_i[31:0], wb_sel_i[3:0], wb_we_i,
//            wb_cyc_i, wb_stb_i (master -> slave);
//            wb_dat_o[31:0], wb_ack_o (slave -> master).
//            Signal names carry the slave's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_pb_led_ctrl_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_pb_led_ctrl_pb_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pb_debounce
// Purpose  : Two-flop synchroniser plus stability counter for an active-low
//            asynchronous push-button. The accepted level only follows the
//            synchronised input after it has differed for DEBOUNCE_CYCLES
//            consecutive cycles. fall_o pulses (combinationally) in the cycle
//            whose closing edge moves the accepted level from 1 to 0.
// Ports    : clk      in  clock
//            rst_n    in  synchronous active-low reset
//            in_n     in  raw button, active low, asynchronous
//            level_o  out accepted (debounced) level, 1 = released
//            fall_o   out press pulse, valid before the edge that commits it
// Revision : 1.0 - initial release
// ============================================================================
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_n,
  output logic level_o,
  output logic fall_o
);

  // A 1-cycle debounce still needs a 1-bit counter to be legal.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = in_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Exposed before the edge so the event register can capture it on the
  // same edge that the accepted level falls.
  assign fall_o  = level_q & ~level_d;
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_pb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_pb_led_ctrl
// Purpose  : Wishbone classic slave giving software control of the board LEDs
//            (static or hardware blink) and the user push-button (debounced
//            level plus sticky press event, optional level interrupt).
// Ports    : wb_clk_i    in  Wishbone clock
//            wb_rst_n_i  in  synchronous active-low reset
//            wb          if  Wishbone slave bundle (wb_pb_led_ctrl_if.slave)
//            pb_n_i      in  raw push-button, active low, asynchronous
//            led_o       out LED drive, active high, registered
//            irq_o       out level interrupt, registered
// Config   : WB_PB_LED_IRQ_EN - when defined, the IRQ_EN register exists and
//            irq_o = registered (PB_EVT & IRQ_EN[0]); otherwise IRQ_EN reads
//            0, ignores writes and irq_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module wb_pb_led_ctrl
  import wb_pb_led_ctrl_pkg::*;
#(
  parameter int unsigned            LED_WIDTH       = 2,
  parameter int unsigned            DEBOUNCE_CYCLES = 240000,
  parameter logic [BLINK_DIV_W-1:0] BLINK_DIV_RESET = 24'd11999999
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  wb_pb_led_ctrl_if.slave      wb,
  input  logic                 pb_n_i,
  output logic [LED_WIDTH-1:0] led_o,
  output logic                 irq_o
);

  // --------------------------------------------------------------------------
  // Push-button conditioning
  // --------------------------------------------------------------------------
  logic pb_level;
  logic pb_fall;

  pb_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pb_debounce (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .in_n    (pb_n_i),
    .level_o (pb_level),
    .fall_o  (pb_fall)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                   ack_q,       ack_d;
  logic [31:0]            dat_q,       dat_d;
  logic [LED_WIDTH-1:0]   led_out_q,   led_out_d;
  logic [LED_WIDTH-1:0]   led_mode_q,  led_mode_d;
  logic [BLINK_DIV_W-1:0] blink_div_q, blink_div_d;
  logic [BLINK_DIV_W-1:0] presc_q,     presc_d;
  logic                   phase_q,     phase_d;
  logic                   pb_evt_q,    pb_evt_d;
  logic [LED_WIDTH-1:0]   led_q,       led_d;
  logic                   irq_q,       irq_d;
`ifdef WB_PB_LED_IRQ_EN
  logic                   irq_en_q,    irq_en_d;
`endif

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic        req;
  logic        wr;
  logic [2:0]  reg_idx;
  logic [31:0] rdata;
  logic        unused_bus_bits;

  // A request is only taken while ack is low, so a held strobe is served
  // every other cycle and each access commits exactly once.
  assign reg_idx = wb.wb_adr_i[4:2];
  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr      = req & wb.wb_we_i;

  // No register reaches byte lane 3 and accesses are word aligned.
  assign unused_bus_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i[31:24], wb.wb_sel_i[3]};

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_LED_OUT:   rdata = 32'(led_out_q);
      REG_LED_MODE:  rdata = 32'(led_mode_q);
      REG_BLINK_DIV: rdata = 32'(blink_div_q);
      REG_PB_STAT: begin
        rdata[PB_STAT_LEVEL_BIT] = pb_level;
        rdata[PB_STAT_EVT_BIT]   = pb_evt_q;
      end
`ifdef WB_PB_LED_IRQ_EN
      REG_IRQ_EN:    rdata[0] = irq_en_q;
`endif
      default:       rdata = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    ack_d       = req;
    dat_d       = req ? rdata : dat_q;
    led_out_d   = led_out_q;
    led_mode_d  = led_mode_q;
    blink_div_d = blink_div_q;
    pb_evt_d    = pb_evt_q;
`ifdef WB_PB_LED_IRQ_EN
    irq_en_d    = irq_en_q;
`endif

    if (wr) begin
      case (reg_idx)
        REG_LED_OUT: begin
          if (wb.wb_sel_i[0]) led_out_d = wb.wb_dat_i[LED_WIDTH-1:0];
        end
        REG_LED_MODE: begin
          if (wb.wb_sel_i[0]) led_mode_d = wb.wb_dat_i[LED_WIDTH-1:0];
        end
        REG_BLINK_DIV: begin
          for (int b = 0; b < BLINK_DIV_W / 8; b++) begin
            if (wb.wb_sel_i[b]) blink_div_d[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
          end
        end
        REG_PB_STAT: begin
          if (wb.wb_sel_i[0] && wb.wb_dat_i[PB_STAT_EVT_BIT]) pb_evt_d = 1'b0;
        end
`ifdef WB_PB_LED_IRQ_EN
        REG_IRQ_EN: begin
          if (wb.wb_sel_i[0]) irq_en_d = wb.wb_dat_i[0];
        end
`endif
        default: ;
      endcase
    end

    // A press in the same cycle as a clear must not be lost.
    if (pb_fall) pb_evt_d = 1'b1;
  end

  // Blink prescaler: a BLINK_DIV write restarts the blink cleanly from the
  // new divider with the phase low.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    if (wr && (reg_idx == REG_BLINK_DIV)) begin
      presc_d = blink_div_d;
      phase_d = 1'b0;
    end else if (presc_q == '0) begin
      presc_d = blink_div_q;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q - 1'b1;
    end
  end

  // Blinking LEDs are gated by the phase, static ones pass LED_OUT through.
  always_comb begin
    led_d = led_out_q & (~led_mode_q | {LED_WIDTH{phase_q}});
`ifdef WB_PB_LED_IRQ_EN
    irq_d = pb_evt_q & irq_en_q;
`else
    irq_d = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      led_out_q   <= '0;
      led_mode_q  <= '0;
      blink_div_q <= BLINK_DIV_RESET;
      presc_q     <= BLINK_DIV_RESET;
      phase_q     <= 1'b0;
      pb_evt_q    <= 1'b0;
      led_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      led_out_q   <= led_out_d;
      led_mode_q  <= led_mode_d;
      blink_div_q <= blink_div_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      pb_evt_q    <= pb_evt_d;
      led_q       <= led_d;
      irq_q       <= irq_d;
    end
  end

`ifdef WB_PB_LED_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
    end
  end
`endif

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign led_o       = led_q;
  assign irq_o       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_pb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_pb_led_ctrl
// Purpose  : Self-checking bench for wb_pb_led_ctrl (LED_WIDTH=2,
//            DEBOUNCE_CYCLES=16). A cycle-level behavioural model of the
//            register map, blink timing and button acceptance runs beside the
//            DUT and is compared on every cycle; directed literal checks pin
//            the model. Honours WB_PB_LED_IRQ_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_pb_led_ctrl;

  localparam int          DEB = 16;
  localparam logic [23:0] BDR = 24'd11999999;
`ifdef WB_PB_LED_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       pb_n  = 1'b1;
  logic [1:0] led;
  logic       irq;

  wb_pb_led_ctrl_if bus();

  wb_pb_led_ctrl #(
    .LED_WIDTH       (2),
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_DIV_RESET (BDR)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus),
    .pb_n_i     (pb_n),
    .led_o      (led),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural model state ----------------
  bit          m_valid = 1'b0;
  logic        m_ack;
  logic [31:0] m_dat;
  logic [1:0]  m_led_out, m_mode, m_led;
  logic [23:0] m_div;
  logic        m_level, m_evt, m_irq_en, m_irq;
  longint      m_edge = 0;
  longint      m_t0   = 0;
  int          m_hist[$];   // m_hist[i] = button value sampled i edges ago

  // Blink phase after edge e: the divider restarts at t0 and the phase flips
  // every (div+1) edges.
  function automatic bit ph(input longint e, input longint t0, input logic [23:0] d);
    return bit'(((e - t0) / (longint'(d) + 1)) % 2);
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] idx);
    case (idx)
      3'd0:    return {30'b0, m_led_out};
      3'd1:    return {30'b0, m_mode};
      3'd2:    return {8'b0, m_div};
      3'd3:    return {30'b0, m_evt, m_level};
      3'd4:    return {31'b0, m_irq_en};
      default: return 32'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus tasks ----------------
  task automatic xfer(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdat);
    bit got = 1'b0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = a;    bus.wb_dat_i = d;    bus.wb_sel_i = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o === 1'b1) got = 1'b1;
    end
    rdat = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: no ack for address 0x%02h, required within 8 cycles", a);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_r;
    xfer(1'b1, a, d, s, unused_r);
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, 32'h0, 4'h0, r);
    chk(name, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;

    fork
      // Model: advances on every rising edge from the inputs the DUT saw.
      forever begin
        logic       o_ph, all_diff, fall, req;
        logic [1:0] n_led_out, n_mode;
        logic [23:0] n_div;
        logic       n_level, n_evt, n_irq_en;
        @(posedge clk);
        m_edge++;
        if (!rst_n) begin
          m_valid = 1'b1;
          m_ack = 1'b0; m_dat = '0; m_led_out = '0; m_mode = '0; m_led = '0;
          m_div = BDR; m_level = 1'b1; m_evt = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
          m_t0 = m_edge;
          m_hist.delete();
          for (int i = 0; i < DEB + 2; i++) m_hist.push_back(1);
        end else if (m_valid) begin
          o_ph = ph(m_edge - 1, m_t0, m_div);
          // Button accepted once the synchronised value (2 edges old) has
          // differed from the level for DEB consecutive edges.
          m_hist.push_front(int'(pb_n));
          void'(m_hist.pop_back());
          all_diff = 1'b1;
          for (int i = 2; i < DEB + 2; i++) if (m_hist[i] == int'(m_level)) all_diff = 1'b0;
          n_level = all_diff ? ~m_level : m_level;
          fall    = all_diff & m_level;

          req = bus.wb_cyc_i & bus.wb_stb_i & ~m_ack;
          n_led_out = m_led_out; n_mode = m_mode; n_div = m_div;
          n_evt = m_evt; n_irq_en = m_irq_en;
          if (req) m_dat = m_rd(bus.wb_adr_i[4:2]);
          if (req && bus.wb_we_i) begin
            case (bus.wb_adr_i[4:2])
              3'd0: if (bus.wb_sel_i[0]) n_led_out = bus.wb_dat_i[1:0];
              3'd1: if (bus.wb_sel_i[0]) n_mode = bus.wb_dat_i[1:0];
              3'd2: begin
                for (int b = 0; b < 3; b++)
                  if (bus.wb_sel_i[b]) n_div[8*b +: 8] = bus.wb_dat_i[8*b +: 8];
                m_t0 = m_edge;
              end
              3'd3: if (bus.wb_sel_i[0] && bus.wb_dat_i[1]) n_evt = 1'b0;
              3'd4: if (IRQ_ON && bus.wb_sel_i[0]) n_irq_en = bus.wb_dat_i[0];
              default: ;
            endcase
          end
          if (fall) n_evt = 1'b1;

          m_led = m_led_out & (~m_mode | {2{o_ph}});
          m_irq = IRQ_ON & m_evt & m_irq_en;
          m_ack = req;
          m_led_out = n_led_out; m_mode = n_mode; m_div = n_div;
          m_level = n_level; m_evt = n_evt; m_irq_en = n_irq_en;
        end
      end
      // Compare: every cycle once the model has seen reset.
      forever begin
        @(negedge clk);
        if (m_valid) begin
          chk("model_ack", 32'(bus.wb_ack_o), 32'(m_ack));
          chk("model_led", 32'(led), 32'(m_led));
          chk("model_irq", 32'(irq), 32'(m_irq));
          if (m_ack) chk("model_dat", bus.wb_dat_o, m_dat);
        end
      end
    join_none

    // ---- 1. reset values ----
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rd("reset_led_out",   5'h00, 32'h0);
    rd("reset_led_mode",  5'h04, 32'h0);
    rd("reset_blink_div", 5'h08, 32'd11999999);
    rd("reset_pb_stat",   5'h0C, 32'h1);
    rd("reset_irq_en",    5'h10, 32'h0);

    // ---- 2. static LED write, byte gating ----
    wr(5'h00, 32'h3, 4'h1);
    @(negedge clk);
    chk("led_static", 32'(led), 32'h3);
    wr(5'h00, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("led_sel0_kept", 32'(led), 32'h3);
    rd("led_out_readback", 5'h00, 32'h3);

    // ---- 3. blink: div=3 -> led[0] toggles every 4 cycles ----
    wr(5'h08, 32'h3, 4'hF);
    wr(5'h04, 32'h1, 4'hF);
    wr(5'h00, 32'h3, 4'hF);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("blink_pattern", 32'(led), {30'b0, 1'b1, 1'(((j + 4) / 4) % 2)});
    end
    wr(5'h04, 32'h0, 4'hF);

    // ---- 4. debounce ----
    pb_n = 1'b0;
    repeat (10) @(negedge clk);
    pb_n = 1'b1;
    repeat (30) @(negedge clk);
    rd("glitch_ignored", 5'h0C, 32'h1);
    pb_n = 1'b0;
    repeat (16) @(negedge clk);
    rd("press_not_yet", 5'h0C, 32'h1);    // acked on edge 17 after the fall
    @(negedge clk);
    rd("press_accepted", 5'h0C, 32'h2);   // acked on edge 19 after the fall
    wr(5'h0C, 32'h2, 4'h1);
    rd("evt_cleared", 5'h0C, 32'h0);
    pb_n = 1'b1;
    repeat (25) @(negedge clk);
    rd("release_no_evt", 5'h0C, 32'h1);

    // ---- 5. interrupt and set-beats-clear ----
    wr(5'h10, 32'h1, 4'h1);
    rd("irq_en_readback", 5'h10, 32'(IRQ_ON));
    pb_n = 1'b0;
    repeat (22) @(negedge clk);
    chk("irq_on_press", 32'(irq), 32'(IRQ_ON));
    wr(5'h0C, 32'h2, 4'h1);
    repeat (2) @(negedge clk);
    chk("irq_after_clear", 32'(irq), 32'h0);
    pb_n = 1'b1;
    repeat (25) @(negedge clk);
    pb_n = 1'b0;
    repeat (17) @(negedge clk);
    wr(5'h0C, 32'h2, 4'h1);               // commits on the press edge
    rd("set_beats_clear", 5'h0C, 32'h2);
    wr(5'h0C, 32'h2, 4'h1);
    pb_n = 1'b1;
    repeat (25) @(negedge clk);

    // ---- 6. reset mid-write, unmapped offsets ----
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 5'h00; bus.wb_dat_i = 32'h3; bus.wb_sel_i = 4'hF;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_ack", 32'(bus.wb_ack_o), 32'h0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rd("reset_mid_led_out", 5'h00, 32'h0);
    rd("reset_mid_div",     5'h08, 32'd11999999);
    wr(5'h14, 32'hFFFF_FFFF, 4'hF);
    rd("unmapped_14", 5'h14, 32'h0);
    rd("unmapped_1c", 5'h1C, 32'h0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
